fetch_stage: RTL and testbench

- Instruction fetch stage of the 3-stage RV32I pipeline; sits directly upstream of the FD pipeline register and feeds ir_FD/pc_FD to decode and to the forwarding/hazard logic.
- Owns the PC, issues one instruction-memory request at a time over a valid/ready request channel with a valid-only response channel, and handles stall and branch flush.
- On flush it redirects to the branch target, squashes in-flight fetches and inserts NOP bubbles into FD.

---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage of the 3-stage RV32I pipeline. Owns the PC, issues
//   one instruction-memory request at a time (valid/ready request, valid-only
//   response), and drives the FD pipeline register consumed by decode and by
//   the forwarding/hazard logic. A taken branch (flush) redirects the PC,
//   squashes any in-flight fetch and writes a NOP bubble into FD.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   synchronous active-low reset
//   stall           in   decode cannot accept; FD holds
//   flush           in   branch taken; redirect to br_target
//   br_target       in   redirect address (bits [1:0] forced to 0)
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   imem accepts request this cycle
//   imem_addr       out  fetch address (current pc)
//   imem_rsp_valid  in   instruction returned this cycle
//   imem_rsp_data   in   returned instruction
//   ir_FD           out  instruction in FD register
//   pc_FD           out  pc of ir_FD
//   valid_FD        out  ir_FD is a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int unsigned      Width    = 32,
   parameter logic [Width-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [Width-1:0] NOP      = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic [Width-1:0] br_target,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [Width-1:0] imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [Width-1:0] imem_rsp_data,
   output logic [Width-1:0] ir_FD,
   output logic [Width-1:0] pc_FD,
   output logic             valid_FD
);

   // REQ : request on the bus          WAIT: accepted, awaiting response
   // HOLD: response parked (stalled)   DROP: squashed fetch still in flight
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [Width-1:0] r_pc;
   logic [Width-1:0] w_pc_nx;
   logic [Width-1:0] r_hold;
   logic [Width-1:0] r_ir_fd;
   logic [Width-1:0] r_pc_fd;
   logic             r_valid_fd;

   logic             w_hs;
   logic             w_deliver;
   logic             w_hold_ld;
   logic [Width-1:0] w_dlv_ir;
   logic [Width-1:0] w_br;
   logic [Width-1:0] w_pc_inc;

   // Word-align the redirect target by masking the low two bits.
   assign w_br     = br_target & ~Width'(3);
   assign w_pc_inc = r_pc + Width'(4);

   // The request is suppressed during reset so imem never sees a stale fetch.
   assign imem_req_valid = (r_state == S_REQ) && rst_n;
   assign imem_addr      = r_pc;
   assign w_hs           = imem_req_valid && imem_req_ready;

   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_deliver  = 1'b0;
      w_hold_ld  = 1'b0;
      w_dlv_ir   = r_hold;
      case (r_state)
         S_REQ: begin
            // A flush retargets the request; if the old address was already
            // accepted this cycle its response must be dropped.
            if (flush) begin
               w_pc_nx    = w_br;
               w_state_nx = w_hs ? S_DROP : S_REQ;
            end else if (w_hs) begin
               w_state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (flush) begin
                  w_pc_nx    = w_br;
                  w_state_nx = S_REQ;
               end else if (!stall) begin
                  w_deliver  = 1'b1;
                  w_dlv_ir   = imem_rsp_data;
                  w_pc_nx    = w_pc_inc;
                  w_state_nx = S_REQ;
               end else begin
                  w_hold_ld  = 1'b1;
                  w_state_nx = S_HOLD;
               end
            end else if (flush) begin
               w_pc_nx    = w_br;
               w_state_nx = S_DROP;
            end
         end
         S_HOLD: begin
            if (flush) begin
               w_pc_nx    = w_br;
               w_state_nx = S_REQ;
            end else if (!stall) begin
               w_deliver  = 1'b1;
               w_dlv_ir   = r_hold;
               w_pc_nx    = w_pc_inc;
               w_state_nx = S_REQ;
            end
         end
         S_DROP: begin
            if (flush) begin
               w_pc_nx = w_br;
            end
            if (imem_rsp_valid) begin
               w_state_nx = S_REQ;
            end
         end
         default: w_state_nx = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_REQ;
         r_pc       <= RESET_PC;
         r_ir_fd    <= NOP;
         r_pc_fd    <= '0;
         r_valid_fd <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
         // FD priority: flush > stall > delivered instruction > bubble.
         if (flush) begin
            r_ir_fd    <= NOP;
            r_pc_fd    <= '0;
            r_valid_fd <= 1'b0;
         end else if (!stall) begin
            if (w_deliver) begin
               r_ir_fd    <= w_dlv_ir;
               r_pc_fd    <= r_pc;
               r_valid_fd <= 1'b1;
            end else begin
               r_ir_fd    <= NOP;
               r_valid_fd <= 1'b0;
            end
         end
      end
   end

   // Hold buffer is qualified by the HOLD state, so its contents need no reset.
   always_ff @(posedge clk) begin
      if (w_hold_ld) begin
         r_hold <= imem_rsp_data;
      end
   end

   assign ir_FD    = r_ir_fd;
   assign pc_FD    = r_pc_fd;
   assign valid_FD = r_valid_fd;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Instructions expected in FD are queued when
//   the corresponding imem response is driven; a monitor pops and compares on
//   each rising edge of valid_FD. Control/address checks are inline.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [31:0] br_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] ir_FD;
   logic [31:0] pc_FD;
   logic        valid_FD;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   logic prev_v = 1'b0;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .br_target      (br_target),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ir_FD          (ir_FD),
      .pc_FD          (pc_FD),
      .valid_FD       (valid_FD)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] ir);
      exp_t e;
      e.pc = pc;
      e.ir = ir;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every new instruction entering FD must match the queue head.
   always @(negedge clk) begin
      if (valid_FD && !prev_v) begin
         total++;
         assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_unexpected observed pc=%h ir=%h expected=none", pc_FD, ir_FD);
         end
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_pc", pc_FD, mon_e.pc);
            chk("sb_ir", ir_FD, mon_e.ir);
         end
      end
      prev_v <= valid_FD;
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br_target = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      tick();
      tick();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_ir", ir_FD, NOP);
      chk("rst_pc_fd", pc_FD, 32'h0);
      chk("rst_valid", 32'(valid_FD), 32'd0);

      rst_n = 1'b1;
      #1;
      chk("req_after_rst", 32'(imem_req_valid), 32'd1);
      chk("addr0", imem_addr, 32'h0);

      // Two back-to-back fetches from a single-cycle imem.
      imem_req_ready = 1'b1; tick();
      chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
      push(32'h0, 32'h0050_0093); tick();
      imem_rsp_valid = 1'b0;
      chk("addr4", imem_addr, 32'h4);
      chk("fd_valid_pulse", 32'(valid_FD), 32'd1);
      imem_req_ready = 1'b1; tick();
      chk("bubble_valid", 32'(valid_FD), 32'd0);
      chk("bubble_ir", ir_FD, NOP);
      chk("bubble_pc_kept", pc_FD, 32'h0);
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0113;
      push(32'h4, 32'h00A0_0113); tick();
      imem_rsp_valid = 1'b0;
      chk("addr8", imem_addr, 32'h8);

      // Response arrives while stalled: parked, no new request for 3 cycles.
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; stall = 1'b1;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_81B3; tick();
      imem_rsp_valid = 1'b0;
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_fd_valid", 32'(valid_FD), 32'd0);
      chk("stall_pc_fd", pc_FD, 32'h4);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      end
      stall = 1'b0;
      push(32'h8, 32'h0020_81B3); tick();
      chk("post_stall_addr", imem_addr, 32'hC);
      chk("post_stall_req", 32'(imem_req_valid), 32'd1);
      stall = 1'b1; tick();
      chk("stall_hold_valid", 32'(valid_FD), 32'd1);
      chk("stall_hold_ir", ir_FD, 32'h0020_81B3);
      chk("stall_hold_pc", pc_FD, 32'h8);
      stall = 1'b0;

      // Flush in WAIT; late response must be dropped.
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; flush = 1'b1; br_target = 32'h40; tick();
      flush = 1'b0;
      chk("flush_pc_fd", pc_FD, 32'h0);
      chk("flush_valid", 32'(valid_FD), 32'd0);
      chk("drop_req", 32'(imem_req_valid), 32'd0);
      tick();
      chk("drop_req2", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; tick();
      imem_rsp_valid = 1'b0;
      chk("redirect_addr", imem_addr, 32'h40);
      chk("redirect_req", 32'(imem_req_valid), 32'd1);
      chk("drop_no_fd", 32'(valid_FD), 32'd0);
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_8093;
      push(32'h40, 32'h0010_8093); tick();
      imem_rsp_valid = 1'b0;

      // Flush together with response in WAIT; unaligned target is aligned.
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; flush = 1'b1; br_target = 32'h103;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_F00D; tick();
      flush = 1'b0; imem_rsp_valid = 1'b0;
      chk("align_addr", imem_addr, 32'h100);
      chk("align_req", 32'(imem_req_valid), 32'd1);
      chk("align_no_fd", 32'(valid_FD), 32'd0);

      // Request not accepted for 4 cycles, retargeted on cycle 2.
      tick();
      chk("retry_addr", imem_addr, 32'h100);
      flush = 1'b1; br_target = 32'h80; tick();
      flush = 1'b0;
      chk("retarget_addr", imem_addr, 32'h80);
      chk("retarget_req", 32'(imem_req_valid), 32'd1);
      tick();
      tick();
      chk("retarget_hold", imem_addr, 32'h80);
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00C0_0193;
      push(32'h80, 32'h00C0_0193); tick();
      imem_rsp_valid = 1'b0;

      // Flush coinciding with handshake: accepted fetch is squashed.
      imem_req_ready = 1'b1; flush = 1'b1; br_target = 32'h200; tick();
      imem_req_ready = 1'b0; flush = 1'b0;
      chk("hs_flush_drop", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF; tick();
      imem_rsp_valid = 1'b0;
      chk("hs_flush_addr", imem_addr, 32'h200);

      // PC wrap at top of address space.
      flush = 1'b1; br_target = 32'hFFFF_FFFC; tick();
      flush = 1'b0;
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
      push(32'hFFFF_FFFC, 32'h0010_0073); tick();
      imem_rsp_valid = 1'b0;
      chk("wrap_addr", imem_addr, 32'h0);

      // Reset while in WAIT with a valid instruction held in FD.
      stall = 1'b1; imem_req_ready = 1'b1; tick();
      chk("pre_rst_valid", 32'(valid_FD), 32'd1);
      chk("pre_rst_pc", pc_FD, 32'hFFFF_FFFC);
      stall = 1'b0; imem_req_ready = 1'b0; rst_n = 1'b0; tick();
      chk("midrst_req", 32'(imem_req_valid), 32'd0);
      chk("midrst_ir", ir_FD, NOP);
      chk("midrst_pc_fd", pc_FD, 32'h0);
      chk("midrst_valid", 32'(valid_FD), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("postrst_addr", imem_addr, 32'h0);
      chk("postrst_req", 32'(imem_req_valid), 32'd1);
      imem_req_ready = 1'b1; tick();
      chk("postrst_wait", 32'(imem_req_valid), 32'd0);
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0093;
      push(32'h0, 32'h0020_0093); tick();
      imem_rsp_valid = 1'b0;
      tick();
      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
